// File: rtl/cic_interpolator_if.sv
// Sample stream bundle for the CIC interpolator: low-rate input handshake and full-rate output.
interface cic_interpolator_if #(
  parameter int INPUT_WIDTH = 12
) ();
  logic signed [INPUT_WIDTH-1:0] d_in;
  logic                          d_in_valid;
  logic                          d_in_ready;
  logic signed [INPUT_WIDTH-1:0] d_out;
  logic                          d_out_valid;

  modport master (
    output d_in,
    output d_in_valid,
    input  d_in_ready,
    input  d_out,
    input  d_out_valid
  );

  modport slave (
    input  d_in,
    input  d_in_valid,
    output d_in_ready,
    output d_out,
    output d_out_valid
  );
endinterface

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: combs at the input rate, zero-stuff by R, integrators at clk rate,
// then a gain-controlled arithmetic shift down to INPUT_WIDTH.
module cic_interpolator #(
  parameter int INPUT_WIDTH         = 12,
  parameter int WIDTH               = 64,
  parameter int INTERPOLATION_RATIO = 16,
  parameter int GAIN_WIDTH          = 8,
  parameter int N_STAGES            = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GAIN_WIDTH-1:0] Gain,
  cic_interpolator_if.slave     s_bus,
  output logic                  d_clk,
  output logic                  underrun
);

  localparam int CntW     = $clog2(INTERPOLATION_RATIO);
  localparam int Headroom = WIDTH - INPUT_WIDTH;
  localparam logic [CntW-1:0] LastCount = CntW'(INTERPOLATION_RATIO - 1);
  localparam logic [CntW-1:0] HalfCount = CntW'(INTERPOLATION_RATIO / 2);

  logic [CntW-1:0]               r_count;
  logic                          r_d_clk;
  logic signed [INPUT_WIDTH-1:0] r_hold;
  logic                          r_hold_valid;
  logic                          r_started;
  logic                          r_primed;
  logic                          r_underrun;
  logic signed [WIDTH-1:0]       r_comb       [N_STAGES];
  logic signed [WIDTH-1:0]       r_comb_delay [N_STAGES];
  logic signed [WIDTH-1:0]       r_integ      [N_STAGES];
  logic signed [INPUT_WIDTH-1:0] r_d_out;
  logic [N_STAGES:0]             r_valid_pipe;

  logic                          w_tick;
  logic                          w_ready;
  logic                          w_xfer;
  logic signed [WIDTH-1:0]       w_x;
  logic signed [WIDTH-1:0]       w_u;
  int                            w_gain;
  int                            w_shift;

  always_comb begin
    w_tick  = (r_count == LastCount);
    w_ready = !r_hold_valid || w_tick;
    w_xfer  = s_bus.d_in_valid && w_ready;
    w_x     = r_hold_valid ? WIDTH'(r_hold) : '0;
    // Zero-stuffing: the newest comb result enters the integrators once per input period
    w_u     = (r_primed && r_count == '0) ? r_comb[N_STAGES-1] : '0;
    w_gain  = int'(Gain);
    w_shift = (w_gain > Headroom) ? 0 : Headroom - w_gain;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_d_clk      <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_started    <= 1'b0;
      r_primed     <= 1'b0;
      r_underrun   <= 1'b0;
      r_d_out      <= '0;
      r_valid_pipe <= '0;
      for (int i = 0; i < N_STAGES; i++) begin
        r_comb[i]       <= '0;
        r_comb_delay[i] <= '0;
        r_integ[i]      <= '0;
      end
    end else begin
      r_count      <= w_tick ? '0 : r_count + 1'b1;
      r_d_clk      <= (r_count < HalfCount);
      r_hold_valid <= w_xfer || (r_hold_valid && !w_tick);
      if (w_xfer) begin
        r_hold    <= s_bus.d_in;
        r_started <= 1'b1;
      end
      if (w_tick) begin
        r_primed <= 1'b1;
        if (!r_hold_valid && r_started) begin
          r_underrun <= 1'b1;
        end
        r_comb_delay[0] <= w_x;
        r_comb[0]       <= w_x - r_comb_delay[0];
        for (int i = 1; i < N_STAGES; i++) begin
          r_comb_delay[i] <= r_comb[i-1];
          r_comb[i]       <= r_comb[i-1] - r_comb_delay[i];
        end
      end
      r_integ[0] <= r_integ[0] + w_u;
      for (int i = 1; i < N_STAGES; i++) begin
        r_integ[i] <= r_integ[i] + r_integ[i-1];
      end
      r_d_out      <= INPUT_WIDTH'(r_integ[N_STAGES-1] >>> w_shift);
      // Valid trails the first tick by the comb-to-output pipeline depth
      r_valid_pipe <= {r_valid_pipe[N_STAGES-1:0], r_primed};
    end
  end

  assign s_bus.d_in_ready  = w_ready;
  assign s_bus.d_out       = r_d_out;
  assign s_bus.d_out_valid = r_valid_pipe[N_STAGES];
  assign d_clk             = r_d_clk;
  assign underrun          = r_underrun;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench: a small N=2/R=4 instance for impulse, handshake and underrun, and a
// default instance for DC gain, gain shifts and reset-to-valid timing.
module tb_cic_interpolator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gain_s;
  logic [7:0] gain_d;
  logic       d_clk_s;
  logic       d_clk_d;
  logic       underrun_s;
  logic       underrun_d;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  int         n_ready;
  int         imp_tab [7] = '{1, 2, 3, 4, 3, 2, 1};

  cic_interpolator_if #(.INPUT_WIDTH(12)) bus_s ();
  cic_interpolator_if #(.INPUT_WIDTH(12)) bus_d ();

  cic_interpolator #(
    .INPUT_WIDTH        (12),
    .WIDTH              (16),
    .INTERPOLATION_RATIO(4),
    .GAIN_WIDTH         (8),
    .N_STAGES           (2)
  ) u_dut_small (
    .clk     (clk),
    .rst     (rst),
    .Gain    (gain_s),
    .s_bus   (bus_s.slave),
    .d_clk   (d_clk_s),
    .underrun(underrun_s)
  );

  cic_interpolator u_dut (
    .clk     (clk),
    .rst     (rst),
    .Gain    (gain_d),
    .s_bus   (bus_d.slave),
    .d_clk   (d_clk_d),
    .underrun(underrun_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int imp_exp(input int c);
    return (c >= 11 && c <= 17) ? imp_tab[c-11] : 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout_s"}, bus_s.d_out, 0);
    check({tag, "_vld_s"}, bus_s.d_out_valid, 0);
    check({tag, "_rdy_s"}, bus_s.d_in_ready, 1);
    check({tag, "_unr_s"}, underrun_s, 0);
    check({tag, "_dclk_s"}, d_clk_s, 0);
    check({tag, "_dout_d"}, bus_d.d_out, 0);
    check({tag, "_vld_d"}, bus_d.d_out_valid, 0);
    check({tag, "_rdy_d"}, bus_d.d_in_ready, 1);
    check({tag, "_unr_d"}, underrun_d, 0);
    check({tag, "_dclk_d"}, d_clk_d, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    gain_s           = 8'd4;
    gain_d           = 8'd36;
    bus_s.d_in       = '0;
    bus_s.d_in_valid = 1'b0;
    bus_d.d_in       = '0;
    bus_d.d_in_valid = 1'b0;
    repeat (3) step();
    check_reset_outputs("por");

    // Cycle c0 begins with count = 0 on both instances
    rst = 1'b0;
    cyc = 0;

    // Impulse 1 then zeros with valid held high: one transfer per tick
    bus_s.d_in_valid = 1'b1;
    bus_s.d_in       = 12'sd1;
    for (int c = 0; c <= 20; c++) begin
      check("imp_ready", bus_s.d_in_ready, (c == 0 || c % 4 == 3));
      check("imp_dclk", d_clk_s, (c >= 1 && (c - 1) % 4 < 2));
      check("imp_vld", bus_s.d_out_valid, (c >= 7));
      check("imp_dout", bus_s.d_out, imp_exp(c));
      check("imp_unr", underrun_s, 0);
      if (c == 13) gain_s = 8'd255;
      step();
      bus_s.d_in = '0;
    end

    // Starve the small instance; the default one has never had a transfer
    bus_s.d_in_valid = 1'b0;
    for (int c = 21; c <= 40; c++) begin
      check("unr_flag", underrun_s, (c >= 28));
      check("unr_dout", bus_s.d_out, 0);
      check("unr_none_before_xfer", underrun_d, 0);
      check("dflt_vld_rise", bus_d.d_out_valid, (c >= 22));
      check("dflt_idle_dout", bus_d.d_out, 0);
      step();
    end

    // DC gain R^(N-1) = 2^16 cancelled by S = 16
    bus_d.d_in_valid = 1'b1;
    bus_d.d_in       = 12'sd100;
    repeat (600) step();
    for (int c = 0; c < 20; c++) begin
      check("dc_pos", bus_d.d_out, 100);
      check("dc_pos_vld", bus_d.d_out_valid, 1);
      step();
    end

    bus_d.d_in = -12'sd100;
    repeat (600) step();
    n_ready = 0;
    for (int c = 0; c < 64; c++) begin
      check("dc_neg", bus_d.d_out, -100);
      if (bus_d.d_in_ready) n_ready++;
      step();
    end
    check("bp_ready_per_64", n_ready, 4);
    check("dc_no_underrun", underrun_d, 0);

    gain_d = 8'd35;
    repeat (2) step();
    for (int c = 0; c < 4; c++) begin
      check("gain35", bus_d.d_out, -50);
      step();
    end
    gain_d = 8'd37;
    repeat (2) step();
    for (int c = 0; c < 4; c++) begin
      check("gain37", bus_d.d_out, -200);
      step();
    end

    // Reset mid-stream: everything cleared, no leftover output after release
    rst = 1'b1;
    bus_s.d_in_valid = 1'b0;
    bus_d.d_in_valid = 1'b0;
    step();
    check_reset_outputs("mid");
    step();
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c <= 30; c++) begin
      check("rel_vld_s", bus_s.d_out_valid, (c >= 7));
      check("rel_vld_d", bus_d.d_out_valid, (c >= 22));
      check("rel_dout_s", bus_s.d_out, 0);
      check("rel_dout_d", bus_d.d_out, 0);
      check("rel_unr_s", underrun_s, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- Multi-stage CIC interpolation filter (transmit-side counterpart of the team's CIC decimator).
- Accepts low-rate signed samples over a valid/ready handshake and runs N comb stages at the input rate.
- Zero-stuffs by INTERPOLATION_RATIO and runs N integrators at the full clk rate, emitting one scaled output sample per clk.
- Sits between the baseband sample source and the DAC/upconverter path.

Parameters:
INPUT_WIDTH, 12, width of d_in and d_out (signed)
WIDTH, 64, internal comb/integrator register width; must be >= INPUT_WIDTH + N_STAGES*log2(INTERPOLATION_RATIO)
INTERPOLATION_RATIO, 16, upsampling factor R; must be >= 2
GAIN_WIDTH, 8, width of Gain
N_STAGES, 5, number of comb stages and number of integrator stages (N); must be >= 1

Ports:
clk  in  1  system clock, output sample rate
rst  in  1  asynchronous, active-high reset
Gain  in  GAIN_WIDTH  output scaling control (unsigned)
d_in  in  INPUT_WIDTH  signed input sample
d_in_valid  in  1  d_in holds a valid sample
d_in_ready  out  1  block can accept d_in this cycle
d_out  out  INPUT_WIDTH  signed interpolated output sample
d_out_valid  out  1  d_out carries filter output
d_clk  out  1  input-rate strobe: high while phase count < R/2
underrun  out  1  sticky flag: a tick found no buffered sample

Behaviour:
- Reset: asserting rst immediately clears every register. Values while in reset:
  - count, hold_valid, comb, comb_delay, integrators: 0
  - d_out = 0, d_out_valid = 0, underrun = 0, d_clk = 0, primed = 0, started = 0
  - d_in_ready = 1
- Reset mid-operation discards all in-flight data; no partial output after release.
- Phase counter count runs free from 0 to R-1 and wraps.
- tick = (count == R-1). Ticks occur every R cycles.
- d_clk is registered: high in the cycle after count is 0..R/2-1, low otherwise.
- Input buffer is a one-entry hold register plus hold_valid.
  - d_in_ready = !hold_valid || tick (combinational).
  - Transfer happens when d_in_valid && d_in_ready at a clk edge: d_in is captured into hold and hold_valid is set.
- On each tick:
  - The comb pipeline consumes x = hold if hold_valid, else 0.
  - hold_valid clears, unless a transfer occurs in the same cycle; then hold is replaced and hold_valid stays 1.
  - If hold_valid = 0 and started = 1, underrun is set and stays set until reset. started is set by the first transfer.
  - primed is set on the first tick.
- Comb section updates only on tick; one register stage per comb stage, all stages updating simultaneously:
  - comb_delay[0] <= x; comb[0] <= x - comb_delay[0]
  - for i >= 1: comb_delay[i] <= comb[i-1]; comb[i] <= comb[i-1] - comb_delay[i]
  - x is sign-extended to WIDTH; all arithmetic is WIDTH-bit two's complement and wraps.
- Zero-stuffing: u = comb[N-1] in the cycle with count == 0 (the cycle after a tick); u = 0 in all other cycles.
- Integrators update every cycle:
  - integ[0] <= integ[0] + u
  - integ[i] <= integ[i] + integ[i-1]
  - All wrap modulo 2^WIDTH.
- Output: d_out <= low INPUT_WIDTH bits of (integ[N-1] >>> S), arithmetic shift.
  - S = WIDTH - INPUT_WIDTH - Gain.
  - If Gain > WIDTH - INPUT_WIDTH, S = 0.
  - No saturation; Gain may change at any cycle and takes effect on the next d_out.
- Latency: a sample consumed at tick k first affects d_out in cycle T(k+N-1) + N + 2, where T(j) is the cycle in which tick j occurs.
- d_out_valid is asserted from cycle T(first tick) + N + 2 onward, every cycle, until reset.
- DC gain is R^(N-1). Impulse-response sum is R^N (N cascaded boxcars of length R).

Test Plan:
- Reset: hold rst high mid-stream, then release -> every register reads 0, d_out_valid = 0, d_in_ready = 1; d_out_valid rises exactly first-tick + N + 2 cycles after release.
- Impulse, overrides N_STAGES=2, R=4, WIDTH=16, INPUT_WIDTH=12, Gain=4 (S=0): feed 1 then zeros every tick -> d_out sequence 1,2,3,4,3,2,1 then 0, first nonzero at T(k+1)+4.
- DC, defaults, Gain=36 (S=16): d_in = 100 every tick -> after settling d_out = 100 on every cycle; d_in = -100 -> d_out = -100.
- Handshake and backpressure: d_in_valid held high -> exactly one transfer per R cycles. Transfer on a tick cycle replaces hold with no lost sample: 5 ramp samples in give 5 distinct comb updates.
- Underrun: after one sample, withhold d_in_valid for 2 ticks -> underrun goes 1 at the first starved tick, stays 1, zeros are consumed; no underrun is flagged before the first transfer.
- Gain clamp: Gain = 255 -> S = 0, d_out = low 12 bits of integ[N-1]; d_clk is high for exactly R/2 of every R cycles.
